// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain master.
// Optional sticky error logic is enabled with FIFO_RD_ERR_EN.
package fifo_rd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
  localparam int SKID_DEPTH = 2;
  localparam int DEF_FIFO_WIDTH = 16;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer; head is a register so the output has no
// combinational path from the FIFO data port.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({wr, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged: head advances, new word fills the tail
          if (occ == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// FIFO read-side master: credit-based pops into a skid buffer, valid/ready out.
// Define FIFO_RD_ERR_EN to add the fifo_underflow input and sticky err.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
`ifdef FIFO_RD_ERR_EN
  input  logic                  fifo_underflow,
`endif
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      rd_count,
  output logic                  err
);

  rd_state_t  state;
  logic       in_flight;
  logic [1:0] occ;
  logic       pop_out;
  logic [2:0] used;
  logic [2:0] limit;

  assign m_valid = (occ != 2'd0);
  assign pop_out = m_valid & m_ready;

  // a word leaving this cycle frees its slot for a pop issued now
  assign used  = {1'b0, occ} + {2'b0, in_flight};
  assign limit = 3'(SKID_DEPTH) + {2'b0, pop_out};

  assign fifo_rd_en = (state == RUN) & ~fifo_empty & (used < limit);
  assign busy = (state != IDLE) | in_flight | (occ != 2'd0);

  fifo_rd_skid #(.W(FIFO_WIDTH)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .wr   (in_flight),
    .din  (fifo_dout),
    .pop  (pop_out),
    .occ  (occ),
    .head (m_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_flight <= 1'b0;
      rd_count  <= '0;
    end else begin
      in_flight <= fifo_rd_en;
      if (pop_out) rd_count <= rd_count + 1'b1;
      unique case (state)
        IDLE:  if (enable) state <= RUN;
        RUN:   if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) state <= RUN;
          else if (!in_flight && occ == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((fifo_underflow & in_flight) | (fifo_rd_en & fifo_empty))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO model, table vectors, directed
// sequences and random traffic checked against a transaction model.
module tb_fifo_rd_drain;

  logic        clk = 1'b0;
  logic        rst, enable, fifo_empty, m_ready;
  logic [15:0] fifo_dout;
  logic        fifo_underflow;
  logic        fifo_rd_en, m_valid, busy, err;
  logic [15:0] m_data, rd_count;

  always #5 clk = ~clk;

  fifo_rd_drain #(.FIFO_WIDTH(16), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_dout      (fifo_dout),
`ifdef FIFO_RD_ERR_EN
    .fifo_underflow (fifo_underflow),
`endif
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy),
    .rd_count       (rd_count),
    .err            (err)
  );

  typedef struct {
    logic [15:0] d;
    int          t;
  } pend_t;

  typedef struct {
    logic        en, rdy;
    logic        rd, v;
    logic [15:0] d;
    logic        b;
    logic [15:0] c;
  } vec_t;

  logic [15:0] fq[$];
  pend_t       pend[$];
  int          mode;
  logic [15:0] mcnt;
  logic        merr, last_er;
  int          cyc;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        tv_on = 1'b0;
  vec_t        tv;
  vec_t        tbl[8];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mode = 0;
    mcnt = '0;
    merr = 1'b0;
    last_er = 1'b0;
  endtask

  task automatic push_fifo(input logic [15:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // one clock: drive, check at negedge, then advance model and FIFO
  task automatic step(input logic en, input logic rdy, input logic rs);
    logic        ev, po, er, ra, eb;
    logic [15:0] ed;
    int          npre;
    enable = en; m_ready = rdy; rst = rs;
    @(negedge clk);
    npre = pend.size();
    ev = npre > 0 && cyc >= pend[0].t + 2;
    ed = ev ? pend[0].d : 16'h0;
    po = ev & rdy;
    er = (mode == 1) && fq.size() > 0 && (npre - int'(po)) < 2;
    eb = (mode != 0) || npre > 0;
    chk("rd_en", fifo_rd_en, er);
    chk("m_valid", m_valid, ev);
    if (ev) chk("m_data", m_data, ed);
    chk("busy", busy, eb);
    chk("rd_count", rd_count, mcnt);
    chk("err", err, merr);
    if (tv_on) begin
      chk("tbl_rd_en", fifo_rd_en, tv.rd);
      chk("tbl_m_valid", m_valid, tv.v);
      if (tv.v) chk("tbl_m_data", m_data, tv.d);
      chk("tbl_busy", busy, tv.b);
      chk("tbl_rd_count", rd_count, tv.c);
    end
    ra = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rs) begin
      model_reset();
    end else begin
      if (fifo_underflow && last_er) merr = 1'b1;
      if (po) begin
        void'(pend.pop_front());
        mcnt++;
      end
      if (er) pend.push_back('{fq[0], cyc});
      case (mode)
        0: if (en) mode = 1;
        1: if (!en) mode = 2;
        2: if (en) mode = 1; else if (npre == 0) mode = 0;
        default: mode = 0;
      endcase
      last_er = er;
    end
`ifndef FIFO_RD_ERR_EN
    merr = 1'b0;
`endif
    if (ra && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_dout = 16'h0; fifo_underflow = 1'b0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_count", rd_count, 16'h0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_err", err, 1'b0);

    // single word: one pop, valid two cycles later
    tbl[0] = '{1, 1, 0, 0, 16'h0, 0, 16'd0};
    tbl[1] = '{1, 1, 1, 0, 16'h0, 1, 16'd0};
    tbl[2] = '{1, 1, 0, 0, 16'h0, 1, 16'd0};
    tbl[3] = '{1, 1, 0, 1, 16'hABCD, 1, 16'd0};
    tbl[4] = '{1, 1, 0, 0, 16'h0, 1, 16'd1};
    tbl[5] = '{0, 1, 0, 0, 16'h0, 1, 16'd1};
    tbl[6] = '{0, 1, 0, 0, 16'h0, 1, 16'd1};
    tbl[7] = '{0, 1, 0, 0, 16'h0, 0, 16'd1};
    step(1'b0, 1'b0, 1'b0);
    push_fifo(16'hABCD);
    tv_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tv = tbl[i];
      step(tv.en, tv.rdy, 1'b0);
    end
    tv_on = 1'b0;

    // 8 words at full rate
    do_reset();
    for (int i = 1; i <= 8; i++) push_fifo(16'(i));
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
    chk("t1_rd_count", rd_count, 16'd8);
    chk("t1_busy", busy, 1'b1);
    chk("t1_rd_en", fifo_rd_en, 1'b0);

    // 8 words with alternating ready
    do_reset();
    for (int i = 1; i <= 8; i++) push_fifo(16'(16'h100 + i));
    for (int i = 0; i < 24; i++) step(1'b1, 1'(i % 2 == 0), 1'b0);
    chk("t2_rd_count", rd_count, 16'd8);

    // disable mid-stream with a full pipeline, then drain
    do_reset();
    for (int i = 0; i < 10; i++) push_fifo(16'(16'h200 + i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    chk("t4_busy", busy, 1'b0);

    // reset with valid output and a pop in flight
    do_reset();
    for (int i = 0; i < 8; i++) push_fifo(16'(16'h300 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_m_valid", m_valid, 1'b0);
    chk("t5_rd_count", rd_count, 16'd0);
    chk("t5_busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);

`ifdef FIFO_RD_ERR_EN
    do_reset();
    push_fifo(16'h400);
    push_fifo(16'h401);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    fifo_underflow = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    fifo_underflow = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("t6_err_sticky", err, 1'b1);
    do_reset();
    chk("t6_err_rst", err, 1'b0);
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (fq.size() < 16 && $urandom_range(0, 99) < 55)
        push_fifo(16'($urandom));
      step(1'($urandom_range(0, 99) < 85),
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
